// File: rtl/fifo_share_ctrl_if.sv
// Bundle between the shared-buffer controller, its producers/consumer and the 10-entry buffer pins.
// slave = controller view, master = surrounding logic (producers, consumer, buffer).
interface fifo_share_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 10
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW  = $clog2(DEPTH + 1);

    logic [NREQ-1:0]          req;
    logic [NREQ-1:0][DW-1:0]  req_data;
    logic [NREQ-1:0]          gnt;
    logic                     pop;
    logic                     pop_ack;
    logic [DW-1:0]            rdata;
    logic [IDW-1:0]           rsrc;
    logic                     rvalid;
    logic                     fifo_wr;
    logic [DW-1:0]            fifo_din;
    logic                     fifo_rd;
    logic [DW-1:0]            fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [LW-1:0]            level;
    logic                     sync_err;

    modport slave (
        input  req, req_data, pop, fifo_dout, fifo_full, fifo_empty,
        output gnt, pop_ack, rdata, rsrc, rvalid, fifo_wr, fifo_din, fifo_rd, level, sync_err
    );

    modport master (
        output req, req_data, pop, fifo_dout, fifo_full, fifo_empty,
        input  gnt, pop_ack, rdata, rsrc, rvalid, fifo_wr, fifo_din, fifo_rd, level, sync_err
    );
endinterface

// File: rtl/fifo_share_ctrl.sv
// Round-robin write arbiter, read gate and source-tag shadow ring for the shared 10-entry buffer.
// Also tracks occupancy and flags any disagreement with the buffer's own full/empty pins.

module fifo_share_lane #(
    parameter int DW = 8
) (
    input  logic          i_gnt,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);
    assign o_data = i_gnt ? i_data : '0;
endmodule

module fifo_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fifo_share_ctrl_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW  = $clog2(DEPTH + 1);

    logic [IDW-1:0]          r_last;
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [LW-1:0]           r_level;
    logic [IDW-1:0]          r_rsrc;
    logic                    r_rvalid;
    logic                    r_sync_err;
    logic [IDW-1:0]          r_tag [DEPTH];

    logic                    w_rd;
    logic                    w_hazard;
    logic                    w_cand_vld;
    logic [IDW-1:0]          w_cand_idx;
    logic [IDW-1:0]          w_scan;
    logic                    w_wr;
    logic [NREQ-1:0]         w_gnt;
    logic [NREQ-1:0][DW-1:0] w_lane_data;
    logic [DW-1:0]           w_din;
    logic                    w_mis;

    assign w_rd = bus.pop & ~bus.fifo_empty;

    // The buffer mis-tracks a simultaneous read+write at these occupancies; let the read win.
    assign w_hazard = w_rd && ((r_level == LW'(1)) || (r_level == LW'(DEPTH - 1)));

    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_idx = '0;
        w_scan     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = IDW'((int'(r_last) + k) % NREQ);
            if (!w_cand_vld && bus.req[w_scan]) begin
                w_cand_vld = 1'b1;
                w_cand_idx = w_scan;
            end
        end
    end

    assign w_wr  = w_cand_vld & ~bus.fifo_full & ~w_hazard;
    assign w_gnt = w_wr ? (NREQ'(1) << w_cand_idx) : '0;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        fifo_share_lane #(.DW(DW)) u_lane (
            .i_gnt  (w_gnt[g]),
            .i_data (bus.req_data[g]),
            .o_data (w_lane_data[g])
        );
    end

    always_comb begin
        w_din = '0;
        for (int i = 0; i < NREQ; i++) w_din = w_din | w_lane_data[i];
    end

    assign w_mis = (bus.fifo_empty != (r_level == '0)) ||
                   (bus.fifo_full  != (r_level == LW'(DEPTH)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last     <= IDW'(NREQ - 1);
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_rsrc     <= '0;
            r_rvalid   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_rvalid   <= w_rd;
            r_sync_err <= r_sync_err | w_mis;
            if (w_wr) begin
                r_last <= w_cand_idx;
                r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rsrc <= r_tag[r_rptr];
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_tag[r_wptr] <= w_cand_idx;
    end

    assign bus.gnt      = w_gnt;
    assign bus.fifo_wr  = w_wr;
    assign bus.fifo_din = w_din;
    assign bus.fifo_rd  = w_rd;
    assign bus.pop_ack  = w_rd;
    assign bus.rdata    = bus.fifo_dout;
    assign bus.rsrc     = r_rsrc;
    assign bus.rvalid   = r_rvalid;
    assign bus.level    = r_level;
    assign bus.sync_err = r_sync_err;
endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Bench for fifo_share_ctrl: behavioural 10-entry buffer, scoreboard of expected (src,data) pops.
module tb_fifo_share_ctrl;
    localparam int NREQ = 4, DW = 8, DEPTH = 10;

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bad_empty = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    fifo_share_ctrl_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) ifc ();

    fifo_share_ctrl #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference buffer: registered dout, flags from its own count
    logic [7:0] bmem [DEPTH];
    int         bw, br, bcnt;
    logic [7:0] bdout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bw <= 0; br <= 0; bcnt <= 0; bdout <= 8'h00;
        end else begin
            if (ifc.fifo_wr && bcnt < DEPTH) begin
                bmem[bw] <= ifc.fifo_din;
                bw <= (bw + 1) % DEPTH;
            end
            if (ifc.fifo_rd && bcnt > 0) begin
                bdout <= bmem[br];
                br <= (br + 1) % DEPTH;
            end
            bcnt <= bcnt + ((ifc.fifo_wr && bcnt < DEPTH) ? 1 : 0) - ((ifc.fifo_rd && bcnt > 0) ? 1 : 0);
        end
    end

    assign ifc.fifo_dout  = bdout;
    assign ifc.fifo_full  = (bcnt == DEPTH);
    assign ifc.fifo_empty = (bcnt == 0) ^ bad_empty;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_rx();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ifc.rvalid) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_unexpected: got src=%0d data=%h, want no rvalid", ifc.rsrc, ifc.rdata);
                end else begin
                    e = sb.pop_front();
                    if (ifc.rdata !== e.data || ifc.rsrc !== e.src) begin
                        n_fail++;
                        $display("FAIL rx_data: got src=%0d data=%h, want src=%0d data=%h",
                                 ifc.rsrc, ifc.rdata, e.src, e.data);
                    end
                end
            end
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [7:0] data);
        exp_t e;
        e.src = src; e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending, want 0", sb.size());
        end
        sb.delete();
        ifc.req = '0; ifc.pop = 1'b0; bad_empty = 1'b0;
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.req = '0; ifc.pop = 1'b0; ifc.req_data = '0;
        step(); step();
        n_tests++;
        if (ifc.level !== 4'd0 || ifc.rvalid !== 1'b0 || ifc.rsrc !== 2'd0 || ifc.sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got level=%0d rvalid=%b rsrc=%0d sync_err=%b, want 0 0 0 0",
                     ifc.level, ifc.rvalid, ifc.rsrc, ifc.sync_err);
        end
        ifc.req = 4'b1111; ifc.pop = 1'b1; #1;
        n_tests++;
        if (ifc.pop_ack !== 1'b0 || ifc.fifo_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd: got pop_ack=%b fifo_rd=%b, want 0 0", ifc.pop_ack, ifc.fifo_rd);
        end
        ifc.req = '0; ifc.pop = 1'b0;
        rst = 1'b0;
        step();
        n_tests++;
        if (ifc.gnt !== 4'b0000 || ifc.fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr: got gnt=%b fifo_wr=%b, want 0000 0", ifc.gnt, ifc.fifo_wr);
        end
    endtask

    task automatic test_basic();
        do_reset();
        ifc.req = 4'b0001; ifc.req_data[0] = 8'hA5; #1;
        n_tests++;
        if (ifc.gnt !== 4'b0001 || ifc.fifo_wr !== 1'b1 || ifc.fifo_din !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_wr: got gnt=%b wr=%b din=%h, want 0001 1 a5", ifc.gnt, ifc.fifo_wr, ifc.fifo_din);
        end
        push(2'd0, 8'hA5);
        step();
        ifc.req = '0;
        n_tests++;
        if (ifc.level !== 4'd1) begin
            n_fail++; $display("FAIL basic_level1: got %0d want 1", ifc.level);
        end
        ifc.pop = 1'b1; #1;
        n_tests++;
        if (ifc.pop_ack !== 1'b1 || ifc.fifo_rd !== 1'b1) begin
            n_fail++; $display("FAIL basic_popack: got %b/%b want 1/1", ifc.pop_ack, ifc.fifo_rd);
        end
        step();
        ifc.pop = 1'b0;
        n_tests++;
        if (ifc.rvalid !== 1'b1 || ifc.level !== 4'd0) begin
            n_fail++; $display("FAIL basic_rvalid: got rvalid=%b level=%0d want 1 0", ifc.rvalid, ifc.level);
        end
        step(); step();
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        for (int n = 0; n < NREQ; n++) ifc.req_data[n] = 8'(n * 8'h11);
        ifc.req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            want = 4'(1 << (c % NREQ));
            n_tests++;
            if (ifc.gnt !== want) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, ifc.gnt, want);
            end
            push(2'(c % NREQ), 8'((c % NREQ) * 8'h11));
            step();
        end
        ifc.req = '0;
        n_tests++;
        if (ifc.level !== 4'd8) begin
            n_fail++; $display("FAIL rr_level: got %0d want 8", ifc.level);
        end
        ifc.pop = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_tests++;
            if (ifc.pop_ack !== 1'b1) begin
                n_fail++; $display("FAIL rr_popack[%0d]: got %b want 1", c, ifc.pop_ack);
            end
            step();
        end
        ifc.pop = 1'b0;
        step(); step();
        n_tests++;
        if (ifc.level !== 4'd0 || ifc.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rr_drain: got level=%0d rvalid=%b want 0 0", ifc.level, ifc.rvalid);
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        ifc.req = 4'b0001;
        for (int c = 0; c < DEPTH; c++) begin
            ifc.req_data[0] = 8'(8'h10 + c);
            push(2'd0, 8'(8'h10 + c));
            step();
        end
        ifc.req = 4'b0100; ifc.req_data[2] = 8'hC4; #1;
        n_tests++;
        if (ifc.level !== 4'd10 || ifc.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL full_hold: got level=%0d gnt=%b want 10 0000", ifc.level, ifc.gnt);
        end
        step();
        ifc.pop = 1'b1; #1;
        n_tests++;
        if (ifc.pop_ack !== 1'b1 || ifc.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL full_pop: got pop_ack=%b gnt=%b want 1 0000", ifc.pop_ack, ifc.gnt);
        end
        step();
        ifc.pop = 1'b0; #1;
        n_tests++;
        if (ifc.gnt !== 4'b0100 || ifc.level !== 4'd9) begin
            n_fail++; $display("FAIL full_regnt: got gnt=%b level=%0d want 0100 9", ifc.gnt, ifc.level);
        end
        push(2'd2, 8'hC4);
        step();
        ifc.req = '0;
        n_tests++;
        if (ifc.level !== 4'd10) begin
            n_fail++; $display("FAIL full_level: got %0d want 10", ifc.level);
        end
        ifc.pop = 1'b1;
        repeat (DEPTH) step();
        ifc.pop = 1'b0;
        step(); step();
    endtask

    task automatic test_hazard();
        do_reset();
        ifc.req = 4'b0001;
        for (int c = 0; c < DEPTH - 1; c++) begin
            ifc.req_data[0] = 8'(8'h30 + c);
            push(2'd0, 8'(8'h30 + c));
            step();
        end
        ifc.req = 4'b0010; ifc.req_data[1] = 8'h7E; ifc.pop = 1'b1; #1;
        n_tests++;
        if (ifc.fifo_rd !== 1'b1 || ifc.fifo_wr !== 1'b0 || ifc.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL haz9_cycle: got rd=%b wr=%b gnt=%b want 1 0 0000", ifc.fifo_rd, ifc.fifo_wr, ifc.gnt);
        end
        step();
        ifc.pop = 1'b0; #1;
        n_tests++;
        if (ifc.level !== 4'd8 || ifc.gnt !== 4'b0010) begin
            n_fail++; $display("FAIL haz9_next: got level=%0d gnt=%b want 8 0010", ifc.level, ifc.gnt);
        end
        push(2'd1, 8'h7E);
        step();
        ifc.req = '0;
        ifc.pop = 1'b1;
        repeat (8) step();
        n_tests++;
        if (ifc.level !== 4'd1) begin
            n_fail++; $display("FAIL haz1_pre: got level=%0d want 1", ifc.level);
        end
        ifc.req = 4'b1000; ifc.req_data[3] = 8'hE1; #1;
        n_tests++;
        if (ifc.fifo_rd !== 1'b1 || ifc.fifo_wr !== 1'b0) begin
            n_fail++; $display("FAIL haz1_cycle: got rd=%b wr=%b want 1 0", ifc.fifo_rd, ifc.fifo_wr);
        end
        step();
        ifc.pop = 1'b0; #1;
        n_tests++;
        if (ifc.level !== 4'd0 || ifc.gnt !== 4'b1000) begin
            n_fail++; $display("FAIL haz1_next: got level=%0d gnt=%b want 0 1000", ifc.level, ifc.gnt);
        end
        push(2'd3, 8'hE1);
        step();
        ifc.req = '0;
        ifc.pop = 1'b1;
        step();
        ifc.pop = 1'b0;
        step(); step();
    endtask

    task automatic test_empty_pop();
        do_reset();
        ifc.pop = 1'b1; #1;
        n_tests++;
        if (ifc.pop_ack !== 1'b0) begin
            n_fail++; $display("FAIL empty_popack: got %b want 0", ifc.pop_ack);
        end
        step();
        n_tests++;
        if (ifc.rvalid !== 1'b0 || ifc.pop_ack !== 1'b0) begin
            n_fail++; $display("FAIL empty_rvalid: got rvalid=%b pop_ack=%b want 0 0", ifc.rvalid, ifc.pop_ack);
        end
        ifc.req = 4'b0001; ifc.req_data[0] = 8'h5A; #1;
        n_tests++;
        if (ifc.gnt !== 4'b0001) begin
            n_fail++; $display("FAIL empty_gnt: got %b want 0001", ifc.gnt);
        end
        push(2'd0, 8'h5A);
        step();
        ifc.req = '0; #1;
        n_tests++;
        if (ifc.pop_ack !== 1'b1) begin
            n_fail++; $display("FAIL empty_popack2: got %b want 1", ifc.pop_ack);
        end
        step();
        ifc.pop = 1'b0;
        n_tests++;
        if (ifc.rvalid !== 1'b1) begin
            n_fail++; $display("FAIL empty_rvalid2: got %b want 1", ifc.rvalid);
        end
        step(); step();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 0; n < NREQ; n++) ifc.req_data[n] = 8'(8'h40 + n);
        ifc.req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            push(2'(c), 8'(8'h40 + c));
            step();
        end
        ifc.req = '0; ifc.pop = 1'b1;
        step();
        ifc.pop = 1'b0;
        n_tests++;
        if (ifc.rvalid !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: got rvalid=%b want 1", ifc.rvalid);
        end
        #2;
        sb.delete();
        rst = 1'b1;
        #1;
        n_tests++;
        if (ifc.rvalid !== 1'b0 || ifc.level !== 4'd0 || ifc.rsrc !== 2'd0 || ifc.sync_err !== 1'b0 ||
            ifc.gnt !== 4'b0000 || ifc.fifo_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_vals: got rvalid=%b level=%0d rsrc=%0d sync_err=%b gnt=%b rd=%b, want all 0",
                     ifc.rvalid, ifc.level, ifc.rsrc, ifc.sync_err, ifc.gnt, ifc.fifo_rd);
        end
        step();
        rst = 1'b0;
        step();
        bad_empty = 1'b1;
        step();
        bad_empty = 1'b0;
        n_tests++;
        if (ifc.sync_err !== 1'b1) begin
            n_fail++; $display("FAIL sync_set: got %b want 1", ifc.sync_err);
        end
        step(); step();
        n_tests++;
        if (ifc.sync_err !== 1'b1) begin
            n_fail++; $display("FAIL sync_sticky: got %b want 1", ifc.sync_err);
        end
        rst = 1'b1; #1;
        n_tests++;
        if (ifc.sync_err !== 1'b0) begin
            n_fail++; $display("FAIL sync_clear: got %b want 0", ifc.sync_err);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        ifc.req = '0; ifc.req_data = '0; ifc.pop = 1'b0;
        fork monitor_rx(); join_none
        test_reset();
        test_basic();
        test_round_robin();
        test_fill_full();
        test_hazard();
        test_empty_pop();
        test_async_reset();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_final: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
